// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder: the active-low segment
// patterns (same constants the encoder side drives) and settle FSM states.
package seg7_scan_decoder_pkg;

   // Segment bus, active-low, index 0 = a ... index 6 = g.
   typedef logic [0:6] seg_t;

   localparam seg_t SEG_0     = 7'b0000001;
   localparam seg_t SEG_1     = 7'b1001111;
   localparam seg_t SEG_2     = 7'b0010010;
   localparam seg_t SEG_3     = 7'b0000110;
   localparam seg_t SEG_4     = 7'b1001100;
   localparam seg_t SEG_5     = 7'b0100100;
   localparam seg_t SEG_6     = 7'b0100000;
   localparam seg_t SEG_7     = 7'b0001111;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0000100;
   localparam seg_t SEG_A     = 7'b0001000;
   localparam seg_t SEG_B     = 7'b1100000;
   localparam seg_t SEG_C     = 7'b0110001;
   localparam seg_t SEG_D     = 7'b1000010;
   localparam seg_t SEG_E     = 7'b0110000;
   localparam seg_t SEG_F     = 7'b0111000;
   localparam seg_t SEG_BLANK = 7'b1111111;

   // Settle filter states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_HELD  = 2'd2
   } settle_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern decoder: maps an active-low segment word to a
// hex nibble, flagging the all-off (blank) and unrecognised (illegal) cases.
module seg7_decode
   import seg7_scan_decoder_pkg::*;
(
   input  logic [0:6] seg_i,
   output logic [3:0] nibble_o,
   output logic       blank_o,
   output logic       illegal_o
);

   // Table lookup; blank and illegal both report nibble 0.
   always_comb begin
      // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
      nibble_o  = 4'h0;
      blank_o   = 1'b0;
      illegal_o = 1'b0;
      case (seg_i)
         SEG_0:     nibble_o = 4'h0;
         SEG_1:     nibble_o = 4'h1;
         SEG_2:     nibble_o = 4'h2;
         SEG_3:     nibble_o = 4'h3;
         SEG_4:     nibble_o = 4'h4;
         SEG_5:     nibble_o = 4'h5;
         SEG_6:     nibble_o = 4'h6;
         SEG_7:     nibble_o = 4'h7;
         SEG_8:     nibble_o = 4'h8;
         SEG_9:     nibble_o = 4'h9;
         SEG_A:     nibble_o = 4'hA;
         SEG_B:     nibble_o = 4'hB;
         SEG_C:     nibble_o = 4'hC;
         SEG_D:     nibble_o = 4'hD;
         SEG_E:     nibble_o = 4'hE;
         SEG_F:     nibble_o = 4'hF;
         SEG_BLANK: blank_o  = 1'b1;
         default:   illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a scanned 7-segment display: registers the segment/select
// bus, waits for it to settle on one digit, captures the decoded nibble into
// a working set and publishes complete frames with a valid/ack handshake.
module seg7_scan_decoder
   import seg7_scan_decoder_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [0:6]              Seg,
   input  logic [NUM_DIGITS-1:0]   DigSel,
   input  logic                    FrameAck,
   output logic [4*NUM_DIGITS-1:0] Value,
   output logic [NUM_DIGITS-1:0]   BlankMask,
   output logic [NUM_DIGITS-1:0]   ErrMask,
   output logic                    FrameValid,
   output logic                    Overrun
);

   localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

   // Input sample and its predecessor, used for change detection.
   logic [0:6]            seg_q, seg_prev_q;
   logic [NUM_DIGITS-1:0] sel_q, sel_prev_q;

   settle_state_e state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          capture;

   logic [4*NUM_DIGITS-1:0] work_val_q, work_val_d;
   logic [NUM_DIGITS-1:0]   work_blank_q, work_blank_d;
   logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;

   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic [NUM_DIGITS-1:0]   err_q, err_d;
   logic                    fv_q, fv_d;
   logic                    ovr_q, ovr_d;

   logic [3:0] dec_nibble;
   logic       dec_blank;
   logic       dec_illegal;
   logic [3:0] zero_cnt;
   logic       sel_legal;
   logic       s_changed;

   seg7_decode u_decode (
      .seg_i     (seg_q),
      .nibble_o  (dec_nibble),
      .blank_o   (dec_blank),
      .illegal_o (dec_illegal)
   );

   // A sample is legal when exactly one digit select is driven low.
   always_comb begin
      zero_cnt = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!sel_q[i]) zero_cnt = zero_cnt + 4'd1;
      end
      sel_legal = (zero_cnt == 4'd1);
      s_changed = (seg_q != seg_prev_q) || (sel_q != sel_prev_q);
   end

   // Settle FSM: count identical legal samples, capture once per dwell.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_legal) begin
               state_d = ST_DWELL;
               cnt_d   = 4'd1;
            end
         end
         ST_DWELL: begin
            if (!sel_legal) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (s_changed) begin
               cnt_d = 4'd1;
            end else if (cnt_q + 4'd1 == STABLE_CNT) begin
               capture = 1'b1;
               state_d = ST_HELD;
               cnt_d   = STABLE_CNT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_HELD: begin
            if (s_changed) begin
               if (sel_legal) begin
                  state_d = ST_DWELL;
                  cnt_d   = 4'd1;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = 4'd0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Frame completion / handshake, then fold in this cycle's capture so a
   // capture on the completion edge lands in the next frame.
   always_comb begin
      work_val_d   = work_val_q;
      work_blank_d = work_blank_q;
      work_err_d   = work_err_q;
      seen_d       = seen_q;
      value_d      = value_q;
      blank_d      = blank_q;
      err_d        = err_q;
      fv_d         = fv_q;
      ovr_d        = ovr_q;

      if (&seen_q) begin
         seen_d = '0;
         if (!fv_q || FrameAck) begin
            value_d = work_val_q;
            blank_d = work_blank_q;
            err_d   = work_err_q;
            fv_d    = 1'b1;
            if (fv_q) ovr_d = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (fv_q && FrameAck) begin
         fv_d  = 1'b0;
         ovr_d = 1'b0;
      end

      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (capture && !sel_q[i]) begin
            work_val_d[4*i +: 4] = dec_nibble;
            work_blank_d[i]      = dec_blank;
            work_err_d[i]        = dec_illegal;
            seen_d[i]            = 1'b1;
         end
      end
   end

   // State registers, cleared asynchronously at any time.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         // NOTE: the working set is reset along with the control state so a frame can never publish X nibbles.
         seg_q        <= '0;
         seg_prev_q   <= '0;
         sel_q        <= '0;
         sel_prev_q   <= '0;
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         work_val_q   <= '0;
         work_blank_q <= '0;
         work_err_q   <= '0;
         seen_q       <= '0;
         value_q      <= '0;
         blank_q      <= '0;
         err_q        <= '0;
         fv_q         <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
         seg_q        <= Seg;
         seg_prev_q   <= seg_q;
         sel_q        <= DigSel;
         sel_prev_q   <= sel_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         work_val_q   <= work_val_d;
         work_blank_q <= work_blank_d;
         work_err_q   <= work_err_d;
         seen_q       <= seen_d;
         value_q      <= value_d;
         blank_q      <= blank_d;
         err_q        <= err_d;
         fv_q         <= fv_d;
         ovr_q        <= ovr_d;
      end
   end

   assign Value      = value_q;
   assign BlankMask  = blank_q;
   assign ErrMask    = err_q;
   assign FrameValid = fv_q;
   assign Overrun    = ovr_q;

endmodule
